// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------------------------
// stage_sequencer
//
// Launches N_STAGES sub-unit engines one after another. A run starts from IDLE on `start`,
// latching `stage_en` as the skip mask. Each enabled stage gets a one-cycle pulse on
// start_out[i]. The sequencer then waits for done_in[i] and moves on to the next enabled
// stage in ascending index order. The run ends with a one-cycle pulse on exactly one of
// `done` (all enabled stages completed), `aborted` (abort seen) or `err` (watchdog expiry).
//
// Optional feature: define SEQ_WATCHDOG_EN to add a per-stage watchdog counter. Without it,
// `err` is tied low and a stage may wait forever.
//
// Parameters
//   N_STAGES     number of chained stages, 1..16
//   TIMEOUT_CYC  watchdog limit in clk cycles per stage, 1..2**TIMEOUT_W-1
//   TIMEOUT_W    width of the watchdog counter
//   IDX_W        (derived) width of the stage index
//
// Ports
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous, active-high reset
//   start      in   request a run; sampled only in IDLE
//   stage_en   in   per-run skip mask, bit i = 1 runs stage i; latched with start
//   abort      in   terminate the current run (ignored in IDLE, but blocks a start there)
//   done_in    in   per-stage completion, level or pulse; only the current stage's bit counts
//   start_out  out  one-cycle launch pulse per stage
//   busy       out  high from the cycle after an accepted start until the run ends
//   cur_stage  out  index of the stage being waited on (0 in IDLE)
//   done       out  one-cycle pulse: all enabled stages completed
//   aborted    out  one-cycle pulse: run ended by abort
//   err        out  one-cycle pulse: watchdog expiry
// ---------------------------------------------------------------------------------------------

module stage_sequencer #(
    parameter int unsigned N_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYC = 200,
    parameter int unsigned TIMEOUT_W   = 8,
    localparam int unsigned IDX_W      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [N_STAGES-1:0] stage_en,
    input  logic                abort,
    input  logic [N_STAGES-1:0] done_in,
    output logic [N_STAGES-1:0] start_out,
    output logic                busy,
    output logic [IDX_W-1:0]    cur_stage,
    output logic                done,
    output logic                aborted,
    output logic                err
);

    // Elaboration-time parameter sanity checks.
    if (N_STAGES < 1 || N_STAGES > 16) begin : gen_bad_n_stages
        $error("stage_sequencer: N_STAGES must be in 1..16");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TIMEOUT_W)) begin : gen_bad_timeout
        $error("stage_sequencer: TIMEOUT_CYC must be in 1..2**TIMEOUT_W-1");
    end

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } state_e;

    state_e                state_q, state_d;
    logic [N_STAGES-1:0]   mask_q, mask_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic                  busy_q, busy_d;
    logic [N_STAGES-1:0]   start_out_q, start_out_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;

`ifdef SEQ_WATCHDOG_EN
    logic [TIMEOUT_W-1:0]  wd_q, wd_d;
    logic                  err_q, err_d;
`endif

    // Stage lookup helpers.
    logic [IDX_W-1:0]      first_idx;   // lowest set bit of the incoming stage_en
    logic [IDX_W-1:0]      next_idx;    // lowest enabled stage above the current one
    logic                  next_found;
    logic                  cur_done;

    always_comb begin
        first_idx = '0;
        for (int i = int'(N_STAGES) - 1; i >= 0; i--) begin
            if (stage_en[i]) begin
                first_idx = IDX_W'(i);
            end
        end

        next_idx   = '0;
        next_found = 1'b0;
        for (int i = int'(N_STAGES) - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(cur_q))) begin
                next_idx   = IDX_W'(i);
                next_found = 1'b1;
            end
        end
    end

    assign cur_done = done_in[cur_q];

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cur_d       = cur_q;
        busy_d      = busy_q;
        start_out_d = '0;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        err_d       = 1'b0;
        wd_d        = wd_q;
`endif

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                cur_d  = '0;
                // An abort in IDLE does nothing by itself but suppresses a coincident start.
                if (start && !abort) begin
                    mask_d = stage_en;
                    if (stage_en == '0) begin
                        // Empty run: report completion at once without ever going busy.
                        done_d = 1'b1;
                    end else begin
                        start_out_d = N_STAGES'(1) << first_idx;
                        cur_d       = first_idx;
                        busy_d      = 1'b1;
                        state_d     = StWait;
`ifdef SEQ_WATCHDOG_EN
                        wd_d        = '0;
`endif
                    end
                end
            end

            StWait: begin
                // Priority: abort, then completion of the current stage, then watchdog.
                if (abort) begin
                    aborted_d = 1'b1;
                    busy_d    = 1'b0;
                    cur_d     = '0;
                    state_d   = StIdle;
                end else if (cur_done) begin
                    if (next_found) begin
                        start_out_d = N_STAGES'(1) << next_idx;
                        cur_d       = next_idx;
`ifdef SEQ_WATCHDOG_EN
                        wd_d        = '0;
`endif
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        cur_d   = '0;
                        state_d = StIdle;
                    end
                end
`ifdef SEQ_WATCHDOG_EN
                // wd_q counts completed waiting cycles of this stage; this cycle is the
                // TIMEOUT_CYC-th one, so err appears TIMEOUT_CYC cycles after the launch.
                else if (wd_q == TIMEOUT_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    cur_d   = '0;
                    state_d = StIdle;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            cur_q       <= '0;
            busy_q      <= 1'b0;
            start_out_q <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cur_q       <= cur_d;
            busy_q      <= busy_d;
            start_out_q <= start_out_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign start_out = start_out_q;
    assign busy      = busy_q;
    assign cur_stage = cur_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

`ifndef SYNTHESIS
    // Output invariants: single launch pulse, single termination pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(start_out_q))
                else $error("stage_sequencer: more than one start_out bit high");
            assert ($onehot0({done_q, aborted_q, err}))
                else $error("stage_sequencer: done/aborted/err overlap");
        end
    end
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_stage_sequencer
//
// Directed bench for stage_sequencer with N_STAGES=3 and TIMEOUT_CYC=5. Inputs are driven
// 1 time unit after each rising edge; outputs are checked at the same point, so each check
// sees the result of the edge just taken. Expected values are hand-computed.
// The watchdog scenario expects err when SEQ_WATCHDOG_EN is defined and a hung stage otherwise.
// ---------------------------------------------------------------------------------------------

module tb_stage_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] stage_en;
    logic       abort;
    logic [2:0] done_in;
    logic [2:0] start_out;
    logic       busy;
    logic [1:0] cur_stage;
    logic       done;
    logic       aborted;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int s1_cnt   = 0;
    logic noise  = 1'b0;

    always #5 clk = ~clk;

    stage_sequencer #(
        .N_STAGES   (3),
        .TIMEOUT_CYC(5),
        .TIMEOUT_W  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stage_en (stage_en),
        .abort    (abort),
        .done_in  (done_in),
        .start_out(start_out),
        .busy     (busy),
        .cur_stage(cur_stage),
        .done     (done),
        .aborted  (aborted),
        .err      (err)
    );

    // Counts launches of stage 1, sampled mid-cycle.
    always @(negedge clk) begin
        if (start_out[1]) s1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] so, input logic b,
                              input logic [1:0] c, input logic d, input logic a,
                              input logic e);
        check({tag, ".start_out"}, 32'(start_out), 32'(so));
        check({tag, ".busy"},      32'(busy),      32'(b));
        check({tag, ".cur_stage"}, 32'(cur_stage), 32'(c));
        check({tag, ".done"},      32'(done),      32'(d));
        check({tag, ".aborted"},   32'(aborted),   32'(a));
        check({tag, ".err"},       32'(err),       32'(e));
    endtask

    // One clock; when noise is on, done_in[1] toggles every cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (noise) done_in[1] = ~done_in[1];
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        stage_en = '0;
        abort    = 1'b0;
        done_in  = '0;
        step();
        step();
        check_outs("reset", 3'b000, 0, 2'd0, 0, 0, 0);
        reset = 1'b0;
        step();
        check_outs("idle", 3'b000, 0, 2'd0, 0, 0, 0);

        // Full run, every stage answers two cycles after its launch; mask change is ignored.
        stage_en = 3'b111;
        start    = 1'b1;
        step();
        start    = 1'b0;
        stage_en = 3'b000;
        for (int s = 0; s < 3; s++) begin
            check_outs($sformatf("t1.launch%0d", s), 3'(1 << s), 1, 2'(s), 0, 0, 0);
            step();
            check_outs($sformatf("t1.wait%0d", s), 3'b000, 1, 2'(s), 0, 0, 0);
            step();
            done_in = 3'(1 << s);
            step();
            done_in = '0;
        end
        check_outs("t1.done", 3'b000, 0, 2'd0, 1, 0, 0);
        step();
        check_outs("t1.after", 3'b000, 0, 2'd0, 0, 0, 0);

        // Skip mask 101 with done_in[1] toggling throughout; stage 0 is zero-wait.
        s1_cnt   = 0;
        stage_en = 3'b101;
        start    = 1'b1;
        noise    = 1'b1;
        step();
        start    = 1'b0;
        stage_en = 3'b111;
        check_outs("t2.launch0", 3'b001, 1, 2'd0, 0, 0, 0);
        done_in[0] = 1'b1;
        step();
        done_in[0] = 1'b0;
        check_outs("t2.launch2", 3'b100, 1, 2'd2, 0, 0, 0);
        step();
        check_outs("t2.wait2a", 3'b000, 1, 2'd2, 0, 0, 0);
        step();
        check_outs("t2.wait2b", 3'b000, 1, 2'd2, 0, 0, 0);
        done_in[2] = 1'b1;
        step();
        done_in[2] = 1'b0;
        check_outs("t2.done", 3'b000, 0, 2'd0, 1, 0, 0);
        noise   = 1'b0;
        done_in = '0;
        step();
        check("t2.no_launch1", 32'(s1_cnt), 32'd0);

        // Empty mask completes immediately without busy.
        stage_en = 3'b000;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check_outs("t3.done", 3'b000, 0, 2'd0, 1, 0, 0);
        step();
        check_outs("t3.after", 3'b000, 0, 2'd0, 0, 0, 0);

        // Abort coincident with done_in[1] while on stage 1, then a fresh run.
        s1_cnt   = 0;
        stage_en = 3'b111;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check_outs("t4.launch0", 3'b001, 1, 2'd0, 0, 0, 0);
        done_in = 3'b001;
        step();
        check_outs("t4.launch1", 3'b010, 1, 2'd1, 0, 0, 0);
        done_in = 3'b010;
        abort   = 1'b1;
        step();
        abort   = 1'b0;
        done_in = '0;
        check_outs("t4.aborted", 3'b000, 0, 2'd0, 0, 1, 0);
        stage_en = 3'b010;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check_outs("t4.restart", 3'b010, 1, 2'd1, 0, 0, 0);
        done_in = 3'b010;
        step();
        done_in = '0;
        check_outs("t4.done", 3'b000, 0, 2'd0, 1, 0, 0);
        step();
        // Abort in IDLE blocks a simultaneous start.
        abort    = 1'b1;
        start    = 1'b1;
        stage_en = 3'b111;
        step();
        abort = 1'b0;
        start = 1'b0;
        check_outs("t4.idle_abort", 3'b000, 0, 2'd0, 0, 0, 0);
        step();
        check_outs("t4.idle_after", 3'b000, 0, 2'd0, 0, 0, 0);

        // start held high during a run; reset lands while waiting on stage 2.
        stage_en = 3'b111;
        start    = 1'b1;
        step();
        check_outs("t5.launch0", 3'b001, 1, 2'd0, 0, 0, 0);
        done_in = 3'b001;
        step();
        check_outs("t5.launch1", 3'b010, 1, 2'd1, 0, 0, 0);
        done_in = 3'b010;
        step();
        check_outs("t5.launch2", 3'b100, 1, 2'd2, 0, 0, 0);
        done_in = '0;
        step();
        check_outs("t5.no_extra", 3'b000, 1, 2'd2, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        check_outs("t5.reset", 3'b000, 0, 2'd0, 0, 0, 0);
        step();
        check_outs("t5.idle", 3'b000, 0, 2'd0, 0, 0, 0);

        // Stage 1 never answers.
        stage_en = 3'b111;
        start    = 1'b1;
        step();
        start    = 1'b0;
        done_in  = 3'b001;
        step();
        done_in  = '0;
        check_outs("t6.launch1", 3'b010, 1, 2'd1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_outs($sformatf("t6.wait%0d", i), 3'b000, 1, 2'd1, 0, 0, 0);
        end
        step();
`ifdef SEQ_WATCHDOG_EN
        check_outs("t6.err", 3'b000, 0, 2'd0, 0, 0, 1);
        step();
        check_outs("t6.after", 3'b000, 0, 2'd0, 0, 0, 0);
`else
        check_outs("t6.hung", 3'b000, 1, 2'd1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step();
        check_outs("t6.still_hung", 3'b000, 1, 2'd1, 0, 0, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_outs("t6.aborted", 3'b000, 0, 2'd0, 0, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
